uart_tx_fsm: RTL and testbench
==============================

Name: uart_tx_fsm

Overview:
- Frame controller for the UART transmitter. It sits directly upstream of the serializer.
- Accepts a parallel byte on Data_Valid and drives the serializer through ser_en.
- Computes and holds the parity bit.
- Muxes start, data, parity and stop bits onto TX_OUT.
- One bit period equals one CLK cycle; CLK is the baud-rate clock.

Parameters:
DATA_WIDTH, 8, payload bits per frame; must match the serializer shift length.

Ports:
CLK  input  1  baud-rate clock, rising edge
RST  input  1  asynchronous active-low reset
Data_Valid  input  1  single-cycle request to send P_DATA
P_DATA  input  DATA_WIDTH  byte to transmit; valid while Data_Valid=1
PAR_EN  input  1  1 = parity bit inserted after the data bits
PAR_TYP  input  1  0 = even parity, 1 = odd parity
ser_data  input  1  registered serial bit from the serializer, LSB first
ser_en  output  1  shift enable to the serializer
busy  output  1  frame in progress; serializer reload blocked
TX_OUT  output  1  UART line; idles high

Behaviour:
- Clock and reset: one clock (CLK). RST is asynchronous, active-low.
- Reset values, applied immediately on RST low, including mid-frame:
  - state = IDLE
  - bit counter = 0
  - held parity bit = 0, held PAR_EN = 0
  - ser_en = 0, busy = 0, TX_OUT = 1
- States: IDLE, START, DATA, PARITY, STOP.
- Bit counter is ceil(log2(DATA_WIDTH)) bits wide. It is cleared on entry to DATA and increments each DATA cycle.
- Accept rule:
  - Data_Valid=1 in IDLE or STOP captures the frame and moves to START next edge.
  - Captured at accept: held parity = PAR_TYP XOR (XOR-reduce P_DATA); held PAR_EN = PAR_EN.
  - The serializer loads P_DATA on the same edge, because Data_Valid & ~busy is true.
  - PAR_EN, PAR_TYP and P_DATA changes after accept do not affect the current frame.
- Data_Valid in START, DATA or PARITY is ignored. No capture, no state change, no pending request.
- Transitions:
  - IDLE -> START on Data_Valid; otherwise stay.
  - START -> DATA after 1 cycle.
  - DATA: stays DATA_WIDTH cycles (counter 0..DATA_WIDTH-1). At counter = DATA_WIDTH-1, go to PARITY if held PAR_EN=1, else STOP.
  - PARITY -> STOP after 1 cycle.
  - STOP -> START if Data_Valid=1 (back-to-back frame, no idle gap); else IDLE.
- Moore outputs, decoded combinationally from registered state and counter:
  - busy = 1 in START, DATA and PARITY; 0 in IDLE and STOP. STOP is deliberately non-busy so the serializer reloads during the stop bit.
  - ser_en = 1 in START, and in DATA while counter < DATA_WIDTH-1. Total is exactly DATA_WIDTH enabled cycles per frame.
  - ser_en compensates for the serializer's one-cycle output register: the bit shifted out on an enabled cycle appears on ser_data during the next cycle.
  - TX_OUT per state: IDLE = 1, START = 0, DATA = ser_data, PARITY = held parity bit, STOP = 1.
- Frame length on TX_OUT: 10 cycles with PAR_EN=0, 11 cycles with PAR_EN=1, start bit included.
- Latency: the start bit appears on TX_OUT in the cycle after the accepting edge.
- Parity of 0x00:
  - even parity bit = 0
  - odd parity bit = 1
- Reset in any state aborts the frame; TX_OUT returns high without a stop bit.

Test Plan:
- Reset: assert RST=0 mid-DATA -> TX_OUT=1, busy=0, ser_en=0 immediately; state IDLE after release.
- Single frame: P_DATA=0xA5, PAR_EN=0, one Data_Valid pulse -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; busy high exactly 9 cycles; ser_en high exactly 8 cycles.
- Parity: P_DATA=0x07, PAR_EN=1, PAR_TYP=0 -> parity bit 1; repeat with PAR_TYP=1 -> parity bit 0; both frames 11 cycles long.
- Back-to-back: Data_Valid with 0x3C asserted during the STOP cycle of the 0xA5 frame -> next cycle is the start bit (no idle gap); 0x3C bits follow LSB first.
- Ignored request: Data_Valid pulse with 0xFF during DATA of the 0xA5 frame -> 0xA5 frame unaltered; line returns to IDLE, no second frame.
- Config hold: toggle PAR_EN 0->1 during DATA of a frame accepted with PAR_EN=0 -> that frame has no parity bit and lasts 10 cycles.

Source files
------------

// File: rtl/uart_tx_fsm.sv
`default_nettype none
//==============================================================================
// Module      : uart_tx_fsm
// Description : UART transmit frame controller. It sequences the start, data,
//               parity and stop bits, and drives the serializer shift enable.
// Revision    : 1.0 - initial release
//==============================================================================
module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Data_Valid,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic                  busy,
  output logic                  TX_OUT
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_par_bit;
  logic             r_par_en;

  logic             w_accept;
  logic             w_par_bit;

  // STOP accepts so back-to-back frames need no idle gap; the serializer
  // reloads on the same edge because busy is low here.
  assign w_accept  = Data_Valid & ((r_state == S_IDLE) | (r_state == S_STOP));
  assign w_par_bit = PAR_TYP ^ (^P_DATA);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_par_bit <= 1'b0;
      r_par_en  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_STOP: begin
          if (w_accept) begin
            r_par_bit <= w_par_bit;
            r_par_en  <= PAR_EN;
            r_state   <= S_START;
          end else begin
            r_state   <= S_IDLE;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_DATA;
        end
        S_DATA: begin
          if (r_cnt == C_LAST) begin
            r_state <= r_par_en ? S_PARITY : S_STOP;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          r_state <= S_STOP;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Enable leads the line by one cycle to cover the serializer output register.
  always_comb begin
    busy   = 1'b0;
    ser_en = 1'b0;
    TX_OUT = 1'b1;
    case (r_state)
      S_START: begin
        busy   = 1'b1;
        ser_en = 1'b1;
        TX_OUT = 1'b0;
      end
      S_DATA: begin
        busy   = 1'b1;
        ser_en = (r_cnt != C_LAST);
        TX_OUT = ser_data;
      end
      S_PARITY: begin
        busy   = 1'b1;
        TX_OUT = r_par_bit;
      end
      default: begin
        busy   = 1'b0;
        ser_en = 1'b0;
        TX_OUT = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fsm.sv
`default_nettype none
//==============================================================================
// Module      : tb_uart_tx_fsm
// Description : Self-checking bench for uart_tx_fsm with a serializer stub and
//               a frame-queue reference model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_uart_tx_fsm;

  logic       CLK;
  logic       RST;
  logic       Data_Valid;
  logic [7:0] P_DATA;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       ser_data;
  logic       ser_en;
  logic       busy;
  logic       TX_OUT;

  int unsigned errors = 0;
  int unsigned checks = 0;

  uart_tx_fsm #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Data_Valid (Data_Valid),
    .P_DATA     (P_DATA),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_data   (ser_data),
    .ser_en     (ser_en),
    .busy       (busy),
    .TX_OUT     (TX_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Serializer stub: loads on Data_Valid & ~busy, shifts LSB first through an output register.
  logic [7:0] r_sr;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sr     <= 8'h00;
      ser_data <= 1'b0;
    end else if (Data_Valid && !busy) begin
      r_sr     <= P_DATA;
    end else if (ser_en) begin
      ser_data <= r_sr[0];
      r_sr     <= r_sr >> 1;
    end
  end

  // Reference model: bits still to appear on the line, one per cycle.
  logic q[$];
  logic m_pen = 1'b0;
  logic last_tx, last_busy, last_en;

  task automatic model_edge(input logic dv, input logic [7:0] d, input logic pen, input logic pt);
    if (dv && q.size() <= 1) begin
      q.delete();
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(d[i]);
      if (pen) q.push_back(pt ^ (^d));
      q.push_back(1'b1);
      m_pen = pen;
    end else if (q.size() > 0) begin
      void'(q.pop_front());
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic e_tx, e_busy, e_en;
    e_tx   = (q.size() > 0) ? q[0] : 1'b1;
    e_busy = (q.size() > 1);
    e_en   = (q.size() > (m_pen ? 3 : 2));
    last_tx = TX_OUT; last_busy = busy; last_en = ser_en;
    check("tx_out", TX_OUT, e_tx);
    check("busy",   busy,   e_busy);
    check("ser_en", ser_en, e_en);
  endtask

  // Starts just after a negedge: drive, clock, model, then sample at next negedge.
  task automatic step(input logic dv, input logic [7:0] d, input logic pen, input logic pt);
    Data_Valid = dv; P_DATA = d; PAR_EN = pen; PAR_TYP = pt;
    @(posedge CLK);
    model_edge(dv, d, pen, pt);
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic do_reset();
    RST = 1'b0;
    #1;
    q.delete();
    m_pen = 1'b0;
    check("rst_tx_out", TX_OUT, 1'b1);
    check("rst_busy",   busy,   1'b0);
    check("rst_ser_en", ser_en, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  // Sends one frame and records line bits plus busy/ser_en counts over n cycles.
  task automatic run_frame(input logic [7:0] d, input logic pen, input logic pt, input int n,
                           output logic [10:0] bits, output int nbusy, output int nen);
    bits = '0; nbusy = 0; nen = 0;
    for (int i = 0; i < n; i++) begin
      step(i == 0, d, pen, pt);
      bits[i] = last_tx;
      nbusy += int'(last_busy);
      nen   += int'(last_en);
    end
  endtask

  logic [10:0] bits;
  logic [9:0]  exp_a5;
  int          nb, ne;

  initial begin
    RST = 1'b1; Data_Valid = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    @(negedge CLK);
    do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // 0xA5 without parity, line pattern from start to stop bit
    exp_a5 = 10'b11010_01010;
    run_frame(8'hA5, 1'b0, 1'b0, 10, bits, nb, ne);
    check_int("a5_line", int'(bits[9:0]), int'(exp_a5));
    check_int("a5_busy_cycles", nb, 9);
    check_int("a5_ser_en_cycles", ne, 8);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("a5_idle_after", TX_OUT, 1'b1);

    // Parity on 0x07: even -> 1, odd -> 0
    run_frame(8'h07, 1'b1, 1'b0, 11, bits, nb, ne);
    check("par_even_bit", bits[9], 1'b1);
    check_int("par_even_len", nb + 1, 11);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    run_frame(8'h07, 1'b1, 1'b1, 11, bits, nb, ne);
    check("par_odd_bit", bits[9], 1'b0);
    check_int("par_odd_len", nb + 1, 11);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Request during DATA is ignored; no second frame follows
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("ignore_no_frame_tx", TX_OUT, 1'b1);
    check("ignore_no_frame_busy", busy, 1'b0);

    // Back-to-back: 0x3C requested during the STOP cycle of 0xA5
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("b2b_in_stop", TX_OUT, 1'b1);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    check("b2b_start_bit", TX_OUT, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b0);

    // PAR_EN raised mid-frame does not add a parity bit
    step(1'b1, 8'h5A, 1'b0, 1'b1);
    nb = 1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b1);
      nb += int'(last_busy);
    end
    check_int("cfg_hold_len", nb + 1, 10);

    // Reset mid-DATA aborts the frame
    step(1'b1, 8'hC3, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("post_rst_idle", TX_OUT, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) == 0, 8'($urandom), 1'($urandom), 1'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
